// File: rtl/sd_pkg.sv
// Shared signed-digit definitions for the sd_mult_accum datapath.
package sd_pkg;

  // Digit encoding {p,n}: value = p - n.
  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // The unused 2'b11 code is treated as zero.
  function automatic logic [1:0] sd_norm(input logic [1:0] d);
    return (d == 2'b11) ? SD_ZERO : d;
  endfunction

  // Integer value of a (normalised or not) digit.
  function automatic logic signed [2:0] sd_val(input logic [1:0] d);
    case (d)
      SD_POS:  return 3'sd1;
      SD_NEG:  return -3'sd1;
      default: return 3'sd0;
    endcase
  endfunction

  // Encode a value in {-1,0,1} as a digit.
  function automatic logic [1:0] sd_enc(input logic signed [2:0] v);
    if (v == 3'sd1)       return SD_POS;
    else if (v == -3'sd1) return SD_NEG;
    else                  return SD_ZERO;
  endfunction

endpackage

// File: rtl/sd_add_cell.sv
// One digit slice of the carry-free signed-digit adder row.
module sd_add_cell
  import sd_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       lo_neg,
  input  logic [1:0] h_in,
  output logic [1:0] h_out,
  output logic [1:0] s
);

  logic signed [2:0] t;
  logic signed [2:0] h;
  logic signed [2:0] w;
  logic signed [2:0] r;

  // Split t = a + b into transfer h and interim w, then absorb the incoming transfer.
  // t = +/-2 always transfers; +/-1 transfers only when the lower sum has the same sign,
  // which keeps w + h_in inside {-1,0,1}.
  always_comb begin
    t = sd_val(a) + sd_val(b);
    h = 3'sd0;
    if (t == 3'sd2 || (t == 3'sd1 && !lo_neg))
      h = 3'sd1;
    else if (t == -3'sd2 || (t == -3'sd1 && lo_neg))
      h = -3'sd1;
    w     = t - (h <<< 1);
    r     = w + sd_val(h_in);
    h_out = sd_enc(h);
    s     = sd_enc(r);
  end

endmodule

// File: rtl/sd_mult_accum.sv
// Sequential MSD-first signed-digit multiply-accumulate: P <- 2P + y*X per accepted digit.
module sd_mult_accum
  import sd_pkg::*;
#(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N-1:0]    x_p,
  input  logic [N-1:0]    x_n,
  input  logic [1:0]      y_dig,
  input  logic            y_valid,
  output logic            y_ready,
  output logic [2*N:0]    z_p,
  output logic [2*N:0]    z_n,
  output logic [2*N+1:0]  z_bin,
  output logic            done,
  output logic            busy
);

  localparam int PW = 2 * N + 1;
  localparam int CW = $clog2(N + 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    xp_r, xn_r;
  logic [PW-1:0]   pp_r, pn_r;

  logic [1:0]      y_n;
  logic [N-1:0]    xp_in, xn_in;
  logic [PW-1:0]   ap, an, bp, bn, sp, sn;
  logic [PW-1:0]   neg_sum, lo_neg;
  logic [PW:0][1:0] hc;
  logic            load, accept, last;
  logic [PW-1:0]   diff;
  logic            unused_bits;

  assign y_n   = sd_norm(y_dig);
  assign xp_in = x_p & ~x_n;
  assign xn_in = x_n & ~x_p;

  // 2P: one-digit shift up; the top digit leaves the register.
  assign ap = {pp_r[PW-2:0], 1'b0};
  assign an = {pn_r[PW-2:0], 1'b0};

  // y*X: X passed, negated or zeroed according to the current Y digit.
  always_comb begin
    bp = '0;
    bn = '0;
    case (y_n)
      SD_POS: begin
        bp[N-1:0] = xp_r;
        bn[N-1:0] = xn_r;
      end
      SD_NEG: begin
        bp[N-1:0] = xn_r;
        bn[N-1:0] = xp_r;
      end
      default: ;
    endcase
  end

  assign hc[0]  = SD_ZERO;
  assign lo_neg = {neg_sum[PW-2:0], 1'b0};

  for (genvar i = 0; i < PW; i++) begin : g_row
    logic signed [2:0] t_i;
    logic [1:0]        s_i;
    assign t_i        = sd_val({ap[i], an[i]}) + sd_val({bp[i], bn[i]});
    assign neg_sum[i] = t_i[2];
    sd_add_cell u_cell (
      .a      ({ap[i], an[i]}),
      .b      ({bp[i], bn[i]}),
      .lo_neg (lo_neg[i]),
      .h_in   (hc[i]),
      .h_out  (hc[i+1]),
      .s      (s_i)
    );
    assign sp[i] = s_i[1];
    assign sn[i] = s_i[0];
  end

  assign unused_bits = ^{hc[PW], pp_r[PW-1], pn_r[PW-1], neg_sum[PW-1]};

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    last      = (cnt == CW'(N - 1));
    y_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        y_ready = 1'b1;
        busy    = 1'b1;
        if (y_valid) begin
          accept = 1'b1;
          if (last) state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, X, P and digit counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      xp_r  <= '0;
      xn_r  <= '0;
      pp_r  <= '0;
      pn_r  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        xp_r <= xp_in;
        xn_r <= xn_in;
        pp_r <= '0;
        pn_r <= '0;
        cnt  <= '0;
      end else if (accept) begin
        pp_r <= sp;
        pn_r <= sn;
        cnt  <= cnt + CW'(1);
      end
    end
  end

  assign z_p = pp_r;
  assign z_n = pn_r;

  // The product always fits a PW-bit signed value, so the difference is formed
  // modulo 2^PW and sign-extended; this equals the exact digit sum for legal P.
  assign diff  = pp_r - pn_r;
  assign z_bin = {diff[PW-1], diff};

endmodule

// File: tb/tb_sd_mult_accum.sv
// Self-checking bench: directed N=4 scenarios plus randomized N=8 operations.
module tb_sd_mult_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N=4 instance
  logic       a_rst_n, a_start, a_y_valid, a_ready, a_done, a_busy;
  logic [3:0] a_xp, a_xn;
  logic [1:0] a_y;
  logic [8:0] a_zp, a_zn;
  logic [9:0] a_zbin;

  // N=8 instance
  logic        b_rst_n, b_start, b_y_valid, b_ready, b_done, b_busy;
  logic [7:0]  b_xp, b_xn;
  logic [1:0]  b_y;
  logic [16:0] b_zp, b_zn;
  logic [17:0] b_zbin;

  sd_mult_accum #(.N(4)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .start(a_start), .x_p(a_xp), .x_n(a_xn),
    .y_dig(a_y), .y_valid(a_y_valid), .y_ready(a_ready), .z_p(a_zp), .z_n(a_zn),
    .z_bin(a_zbin), .done(a_done), .busy(a_busy)
  );

  sd_mult_accum #(.N(8)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .start(b_start), .x_p(b_xp), .x_n(b_xn),
    .y_dig(b_y), .y_valid(b_y_valid), .y_ready(b_ready), .z_p(b_zp), .z_n(b_zn),
    .z_bin(b_zbin), .done(b_done), .busy(b_busy)
  );

  // Reference: value of a digit vector (11 counts as 0).
  function automatic longint vec_val(input logic [15:0] p, input logic [15:0] n, input int w);
    longint v = 0;
    for (int i = 0; i < w; i++) begin
      if (p[i] && !n[i]) v += (longint'(1) << i);
      else if (n[i] && !p[i]) v -= (longint'(1) << i);
    end
    return v;
  endfunction

  // Reference: value of a Y digit stream, first digit most significant.
  function automatic longint y_val(input logic [15:0] yd, input int n);
    longint v = 0;
    logic [1:0] d;
    for (int k = 0; k < n; k++) begin
      d = yd[2*k +: 2];
      v = v * 2;
      if (d == 2'b10) v += 1;
      else if (d == 2'b01) v -= 1;
    end
    return v;
  endfunction

  task automatic a_begin(input logic [3:0] xp, input logic [3:0] xn);
    a_xp = xp; a_xn = xn; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_xp = 4'($urandom); a_xn = 4'($urandom);
    checks++;
    if (a_ready !== 1'b1 || a_busy !== 1'b1 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL a_begin: ready=%b busy=%b done=%b required 1 1 0", a_ready, a_busy, a_done);
    end
  endtask

  task automatic a_feed(input logic [7:0] yd, input logic [3:0] bub, input logic start_mid,
                        input longint expv, input string name);
    longint got;
    for (int k = 0; k < 4; k++) begin
      a_y_valid = 1'b1; a_y = yd[2*k +: 2];
      if (start_mid && k == 1) a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      if (k < 3) begin
        checks++;
        if (a_done !== 1'b0 || a_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s run k=%0d: done=%b ready=%b required 0 1", name, k, a_done, a_ready);
        end
        if (bub[k]) begin
          a_y_valid = 1'b0; a_y = 2'($urandom);
          @(negedge clk);
          checks++;
          if (a_done !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s bubble k=%0d: done=%b ready=%b required 0 1", name, k, a_done, a_ready);
          end
        end
      end
    end
    a_y_valid = 1'b0;
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s done: done=%b busy=%b ready=%b required 1 0 0", name, a_done, a_busy, a_ready);
    end
    got = longint'($signed(a_zbin));
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s z_bin: got %0d required %0d", name, got, expv);
    end
    checks++;
    if ((a_zp & a_zn) !== 9'd0) begin
      errors++;
      $display("FAIL %s code11: z_p=%b z_n=%b required no common bit", name, a_zp, a_zn);
    end
  endtask

  task automatic test_reset;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_start = 1'b1; b_start = 1'b1; a_y_valid = 1'b1; b_y_valid = 1'b1;
    a_xp = 4'hF; a_xn = 4'h0; b_xp = 8'hFF; b_xn = 8'h00; a_y = 2'b10; b_y = 2'b10;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({a_zp, a_zn, a_zbin, a_ready, a_done, a_busy} !== '0) begin
      errors++;
      $display("FAIL reset_a: z_p=%h z_n=%h z_bin=%h ready=%b done=%b busy=%b required all 0",
               a_zp, a_zn, a_zbin, a_ready, a_done, a_busy);
    end
    checks++;
    if ({b_zp, b_zn, b_zbin, b_ready, b_done, b_busy} !== '0) begin
      errors++;
      $display("FAIL reset_b: z_p=%h z_n=%h z_bin=%h ready=%b done=%b busy=%b required all 0",
               b_zp, b_zn, b_zbin, b_ready, b_done, b_busy);
    end
    a_start = 1'b0; b_start = 1'b0; a_y_valid = 1'b0; b_y_valid = 1'b0;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
    // y_valid outside RUN must not start anything
    a_y_valid = 1'b1;
    @(negedge clk);
    a_y_valid = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || a_ready !== 1'b0 || a_zbin !== 10'd0) begin
      errors++;
      $display("FAIL idle_valid: busy=%b ready=%b z_bin=%0d required 0 0 0", a_busy, a_ready, a_zbin);
    end
  endtask

  task automatic test_basic;
    logic [7:0] yd;
    yd = 8'b10_01_00_10;   // +1, 0, -1, +1 -> +7
    a_begin(4'b0101, 4'b0000);
    a_feed(yd, 4'b0000, 1'b0, 35, "basic");
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0 || $signed(a_zbin) !== 10'sd35) begin
      errors++;
      $display("FAIL basic_idle: done=%b busy=%b z_bin=%0d required 0 0 35", a_done, a_busy, $signed(a_zbin));
    end
    @(negedge clk);
    checks++;
    if ($signed(a_zbin) !== 10'sd35) begin
      errors++;
      $display("FAIL basic_hold: z_bin=%0d required 35", $signed(a_zbin));
    end
  endtask

  task automatic test_negative;
    a_begin(4'b0000, 4'b1000);
    a_feed(8'b10_10_10_10, 4'b0000, 1'b0, -120, "neg_max");
    @(negedge clk);
  endtask

  task automatic test_bubbles;
    a_begin(4'b0101, 4'b0000);
    a_feed(8'b10_01_00_10, 4'b0101, 1'b0, 35, "bubbles");
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    a_begin(4'b0101, 4'b0000);
    a_y_valid = 1'b1; a_y = 2'b10;
    @(negedge clk);
    a_y = 2'b01;
    @(negedge clk);
    a_y_valid = 1'b0;
    a_rst_n = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1;
    checks++;
    if ({a_zp, a_zn, a_zbin, a_ready, a_done, a_busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid: z_bin=%0d ready=%b done=%b busy=%b required 0 0 0 0",
               $signed(a_zbin), a_ready, a_done, a_busy);
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_nodone: done=%b busy=%b required 0 0", a_done, a_busy);
    end
    a_begin(4'b0101, 4'b0000);
    a_feed(8'b10_01_00_10, 4'b0000, 1'b0, 35, "after_reset");
    @(negedge clk);
  endtask

  task automatic test_norm;
    logic [3:0] xp, xn;
    logic [7:0] yd;
    xp = 4'b1101; xn = 4'b1000;     // top digit is code 11
    yd = 8'b10_01_11_10;            // second digit is code 11
    a_begin(xp, xn);
    a_feed(yd, 4'b0000, 1'b0, vec_val({12'd0, xp}, {12'd0, xn}, 4) * y_val({8'd0, yd}, 4), "norm11");
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    a_begin(4'b0101, 4'b0000);
    a_feed(8'b10_01_00_10, 4'b0000, 1'b0, 35, "b2b_first");
    // still in the done cycle: start here re-enters RUN directly
    a_begin(4'b0011, 4'b0100);      // -4+2+1 = -1
    a_feed(8'b01_10_10_01, 4'b0000, 1'b1, -(-8 + 4 + 2 - 1), "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_random;
    int         ops;
    logic [7:0] xp, xn;
    logic [15:0] yd;
    logic [7:0] bub;
    longint     expv, got;
    ops = 1000;
    for (int op = 0; op < ops; op++) begin
      xp = 8'($urandom); xn = 8'($urandom);
      yd = 16'($urandom);
      bub = 8'($urandom) & 8'($urandom);
      expv = vec_val({8'd0, xp}, {8'd0, xn}, 8) * y_val(yd, 8);
      b_xp = xp; b_xn = xn; b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0; b_xp = 8'($urandom); b_xn = 8'($urandom);
      checks++;
      if (b_ready !== 1'b1 || b_busy !== 1'b1) begin
        errors++;
        $display("FAIL rand_start op=%0d: ready=%b busy=%b required 1 1", op, b_ready, b_busy);
      end
      for (int k = 0; k < 8; k++) begin
        b_y_valid = 1'b1; b_y = yd[2*k +: 2];
        b_start = ($urandom_range(0, 7) == 0);
        @(negedge clk);
        b_start = 1'b0;
        if (k < 7) begin
          checks++;
          if (b_done !== 1'b0 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL rand_run op=%0d k=%0d: done=%b ready=%b required 0 1", op, k, b_done, b_ready);
          end
          if (bub[k]) begin
            b_y_valid = 1'b0; b_y = 2'($urandom);
            @(negedge clk);
          end
        end
      end
      b_y_valid = 1'b0;
      checks++;
      if (b_done !== 1'b1) begin
        errors++;
        $display("FAIL rand_done op=%0d: done=%b required 1", op, b_done);
      end
      got = longint'($signed(b_zbin));
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL rand_z op=%0d: got %0d required %0d (x_p=%b x_n=%b y=%h)", op, got, expv, xp, xn, yd);
      end
      checks++;
      if ((b_zp & b_zn) !== 17'd0) begin
        errors++;
        $display("FAIL rand_code11 op=%0d: z_p=%b z_n=%b", op, b_zp, b_zn);
      end
      // half the time chain directly from the done cycle, otherwise idle a cycle
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
  endtask

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0; a_y_valid = 1'b0; b_y_valid = 1'b0;
    a_xp = '0; a_xn = '0; b_xp = '0; b_xn = '0; a_y = '0; b_y = '0;
    test_reset;
    test_basic;
    test_negative;
    test_bubbles;
    test_reset_mid;
    test_norm;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
